// File: rtl/rs_ff_bank.sv
// Bank of WIDTH clocked RS flip-flops with selectable S=R=1 resolution, edge pulses and conflict flag.
// Optional saturating conflict counter is built when RS_FF_BANK_CONFLICT_CNT_EN is defined.
module rs_ff_bank #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       MODE      = 0,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             Clr_cnt,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall,
  output logic             Conflict,
  output logic [CNT_W-1:0] Conf_cnt
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rise_q, fall_q;
  logic             conflict_q, conflict_d;

  always_comb begin
    q_d = q_q;
    if (En) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({S[i], R[i]})
          2'b10:   q_d[i] = 1'b1;
          2'b01:   q_d[i] = 1'b0;
          2'b11: begin
            // Any MODE outside 0..2 resolves as hold.
            case (MODE)
              0:       q_d[i] = 1'b1;
              1:       q_d[i] = 1'b0;
              2:       q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end
  end

  assign conflict_d = En & (|(S & R));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_q        <= RESET_VAL;
      rise_q     <= '0;
      fall_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      rise_q     <= q_d & ~q_q;
      fall_q     <= ~q_d & q_q;
      conflict_q <= conflict_d;
    end
  end

`ifdef RS_FF_BANK_CONFLICT_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q;

  // Clear beats a simultaneous conflict; counting stops at CntMax.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (Clr_cnt) begin
      cnt_q <= '0;
    end else if (conflict_d && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Conf_cnt = cnt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = Clr_cnt;
  assign Conf_cnt       = '0;
`endif

  assign Q        = q_q;
  assign Qn       = ~q_q;
  assign Rise     = rise_q;
  assign Fall     = fall_q;
  assign Conflict = conflict_q;

endmodule
